// File: rtl/sd_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// sd_seq_ctrl_if
// Bundle of handshake and detector signals between the sequence controller
// and its environment.
//
//   in_valid/in_data/in_ready : parallel word input handshake
//   abort                     : cancel of the word currently being shifted
//   det_bit/det_en/det_hit    : serial stream into, and Mealy hit back from,
//                               the pattern detector
//   hit_cnt/res_valid/res_ready: per-word result handshake
//   hit_pos                   : hit position map (only with SD_SEQ_CTRL_HITPOS_EN)
//
// Modports: slave = controller side, master = environment side.
// -----------------------------------------------------------------------------
interface sd_seq_ctrl_if #(
    parameter int DW = 8
);
    logic                      in_valid;
    logic [DW-1:0]             in_data;
    logic                      in_ready;
    logic                      abort;
    logic                      det_bit;
    logic                      det_en;
    logic                      det_hit;
    logic [$clog2(DW+1)-1:0]   hit_cnt;
    logic                      res_valid;
    logic                      res_ready;
`ifdef SD_SEQ_CTRL_HITPOS_EN
    logic [DW-1:0]             hit_pos;
`endif

    modport slave (
        input  in_valid, in_data, abort, det_hit, res_ready,
`ifdef SD_SEQ_CTRL_HITPOS_EN
        output hit_pos,
`endif
        output in_ready, det_bit, det_en, hit_cnt, res_valid
    );

    modport master (
        output in_valid, in_data, abort, det_hit, res_ready,
`ifdef SD_SEQ_CTRL_HITPOS_EN
        input  hit_pos,
`endif
        input  in_ready, det_bit, det_en, hit_cnt, res_valid
    );
endinterface

// File: rtl/sd_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sd_seq_ctrl
// Accepts a DW-bit word, serializes it MSB first into an external sequence
// detector (one bit per cycle for DW cycles), counts the detector's hits and
// presents the count as a result that is held until consumed.
//
// Ports:
//   clk   : clock, all state changes on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sd_seq_ctrl_if.slave (word input, detector stream, result output)
//
// Optional feature: define SD_SEQ_CTRL_HITPOS_EN to add bus.hit_pos, a map of
// which in_data bit positions triggered a detector hit.
//
// The detector itself is never reset or re-initialized from here; stream
// continuity across words is left to the detector.
// -----------------------------------------------------------------------------
module sd_seq_ctrl #(
    parameter int DW = 8
) (
    input logic          clk,
    input logic          rst_n,
    sd_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(DW + 1);
    localparam int BW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        REPORT = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] shreg_q;
    logic [CW-1:0] cnt_q;
    logic [BW-1:0] bit_q;
    logic          accept;
    logic          shifting;
    logic          last_bit;

    assign accept   = bus.in_valid && (state_q == IDLE);
    // abort removes the current bit from the stream in the same cycle
    assign shifting = (state_q == SHIFT) && !bus.abort;
    assign last_bit = (bit_q == BW'(DW - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = SHIFT;
            SHIFT:   if (bus.abort)     state_d = IDLE;   // abort beats the last bit
                     else if (last_bit) state_d = REPORT;
            REPORT:  if (bus.res_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else if (accept) begin
            shreg_q <= bus.in_data;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else if (state_q == SHIFT) begin
            if (bus.abort) begin
                shreg_q <= '0;
                cnt_q   <= '0;
                bit_q   <= '0;
            end else begin
                shreg_q <= {shreg_q[DW-2:0], 1'b0};
                bit_q   <= last_bit ? '0 : bit_q + BW'(1);
                if (bus.det_hit && (cnt_q != CW'(DW))) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

`ifdef SD_SEQ_CTRL_HITPOS_EN
    // Hits are shifted in from the LSB; after exactly DW shifts the hit on
    // shift cycle k lands on bit DW-1-k, i.e. the in_data position it came from.
    logic [DW-1:0] pos_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else if (accept) begin
            pos_q <= '0;
        end else if (state_q == SHIFT) begin
            if (bus.abort) begin
                pos_q <= '0;
            end else begin
                pos_q <= {pos_q[DW-2:0], bus.det_hit};
            end
        end
    end

    assign bus.hit_pos = pos_q;
`else
    // Hit position tracking not built.
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.det_en    = shifting;
    assign bus.det_bit   = shifting && shreg_q[DW-1];
    assign bus.res_valid = (state_q == REPORT);
    assign bus.hit_cnt   = cnt_q;

endmodule

// File: tb/tb_sd_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sd_seq_ctrl
// Self-checking bench for sd_seq_ctrl (DW=8). The detector is a stub driven
// from a per-word hit mask: bit DW-1-k of the mask is the det_hit value on
// shift cycle k. Expected stream bits, counts and hit maps come from the word
// and the mask directly.
// -----------------------------------------------------------------------------
module tb_sd_seq_ctrl;
    localparam int DW = 8;
    localparam int CW = $clog2(DW + 1);

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sd_seq_ctrl_if #(.DW(DW)) dut_if ();

    sd_seq_ctrl #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Check of every output while no word is in flight.
    task automatic check_idle(input string tag, input logic [CW-1:0] exp_cnt, input bit chk_cnt);
        total++;
        if (dut_if.in_ready !== 1'b1) begin
            bad++; $display("FAIL %s in_ready got=%b exp=1", tag, dut_if.in_ready);
        end
        total++;
        if (dut_if.res_valid !== 1'b0) begin
            bad++; $display("FAIL %s res_valid got=%b exp=0", tag, dut_if.res_valid);
        end
        total++;
        if (dut_if.det_en !== 1'b0 || dut_if.det_bit !== 1'b0) begin
            bad++; $display("FAIL %s det_en/det_bit got=%b/%b exp=0/0", tag, dut_if.det_en, dut_if.det_bit);
        end
        if (chk_cnt) begin
            total++;
            if (dut_if.hit_cnt !== exp_cnt) begin
                bad++; $display("FAIL %s hit_cnt got=%0d exp=%0d", tag, dut_if.hit_cnt, exp_cnt);
            end
`ifdef SD_SEQ_CTRL_HITPOS_EN
            total++;
            if (dut_if.hit_pos !== '0) begin
                bad++; $display("FAIL %s hit_pos got=%b exp=0", tag, dut_if.hit_pos);
            end
`endif
        end
    endtask

    // One word: called at a falling edge with the controller idle, returns at
    // a falling edge with the controller idle again.
    //   cut_at : shift cycle at which to abort / reset (-1 = none)
    //   hold   : keep in_valid high throughout (back-to-back traffic)
    //   noise  : toggle abort/det_hit randomly while the result is held
    task automatic run_word(input string tag, input logic [DW-1:0] data,
                            input logic [DW-1:0] mask, input int stall,
                            input int cut_at, input bit cut_rst,
                            input bit hold, input bit noise);
        logic [CW-1:0] exp_cnt;
        logic          exp_en;
        logic          exp_bit;
        exp_cnt = CW'($countones(mask));

        total++;
        if (dut_if.in_ready !== 1'b1) begin
            bad++; $display("FAIL %s start_ready got=%b exp=1", tag, dut_if.in_ready);
        end
        dut_if.in_valid = 1'b1;
        dut_if.in_data  = data;
        dut_if.abort    = 1'b0;
        dut_if.det_hit  = 1'b0;

        for (int k = 0; k < DW; k++) begin
            @(negedge clk);
            if (!hold) dut_if.in_valid = 1'b0;
            dut_if.det_hit = mask[DW-1-k];
            if (k == cut_at) begin
                if (cut_rst) rst_n = 1'b0;
                else         dut_if.abort = 1'b1;
            end
            #1;
            exp_en  = (k != cut_at);
            exp_bit = exp_en && data[DW-1-k];
            total++;
            if (dut_if.det_en !== exp_en) begin
                bad++; $display("FAIL %s det_en[%0d] got=%b exp=%b", tag, k, dut_if.det_en, exp_en);
            end
            total++;
            if (dut_if.det_bit !== exp_bit) begin
                bad++; $display("FAIL %s det_bit[%0d] got=%b exp=%b", tag, k, dut_if.det_bit, exp_bit);
            end
            total++;
            if (dut_if.res_valid !== 1'b0 || (k != cut_at || !cut_rst) && dut_if.in_ready !== 1'b0) begin
                bad++; $display("FAIL %s shift_hs[%0d] got res_valid=%b in_ready=%b exp=0/0",
                                tag, k, dut_if.res_valid, dut_if.in_ready);
            end
            if (k == cut_at) begin
                if (cut_rst) check_idle({tag, "_in_reset"}, '0, 1'b1);
                @(negedge clk);
                dut_if.in_valid = 1'b0;
                dut_if.abort    = 1'b0;
                dut_if.det_hit  = 1'b0;
                rst_n           = 1'b1;
                #1;
                check_idle({tag, "_after_cut"}, '0, cut_rst);
                return;
            end
        end

        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            dut_if.det_hit   = noise ? 1'($urandom) : 1'b0;
            dut_if.abort     = noise ? 1'($urandom) : 1'b0;
            dut_if.res_ready = (s == stall);
            #1;
            total++;
            if (dut_if.res_valid !== 1'b1 || dut_if.in_ready !== 1'b0) begin
                bad++; $display("FAIL %s report[%0d] got res_valid=%b in_ready=%b exp=1/0",
                                tag, s, dut_if.res_valid, dut_if.in_ready);
            end
            total++;
            if (dut_if.hit_cnt !== exp_cnt) begin
                bad++; $display("FAIL %s hit_cnt[%0d] got=%0d exp=%0d", tag, s, dut_if.hit_cnt, exp_cnt);
            end
`ifdef SD_SEQ_CTRL_HITPOS_EN
            total++;
            if (dut_if.hit_pos !== mask) begin
                bad++; $display("FAIL %s hit_pos[%0d] got=%b exp=%b", tag, s, dut_if.hit_pos, mask);
            end
`endif
            total++;
            if (dut_if.det_en !== 1'b0 || dut_if.det_bit !== 1'b0) begin
                bad++; $display("FAIL %s report_det[%0d] got=%b/%b exp=0/0", tag, s, dut_if.det_en, dut_if.det_bit);
            end
        end

        @(negedge clk);
        dut_if.res_ready = 1'b0;
        dut_if.abort     = 1'b0;
        dut_if.det_hit   = 1'b0;
        #1;
        total++;
        if (dut_if.res_valid !== 1'b0 || dut_if.in_ready !== 1'b1) begin
            bad++; $display("FAIL %s consumed got res_valid=%b in_ready=%b exp=0/1",
                            tag, dut_if.res_valid, dut_if.in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        dut_if.in_valid  = 1'b0;
        dut_if.in_data   = '0;
        dut_if.abort     = 1'b0;
        dut_if.det_hit   = 1'b0;
        dut_if.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle("reset_held", '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_idle("reset_released", '0, 1'b1);
    endtask

    task automatic test_stream_a5();
        run_word("a5_nohit", 8'hA5, 8'h00, 0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_all_hits();
        run_word("all_hits", 8'h3C, 8'hFF, 0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_pulse_hits();
        run_word("pulse_2_5", 8'hC3, 8'b0010_0100, 0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_word("stall5", 8'h96, 8'b1001_0001, 5, -1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_word("b2b_first", 8'h5A, 8'b0110_0000, 1, -1, 1'b0, 1'b1, 1'b0);
        run_word("b2b_second", 8'hE1, 8'b0000_0011, 0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        run_word("abort3", 8'hFF, 8'hFF, 0, 3, 1'b0, 1'b0, 1'b0);
        run_word("abort7_last", 8'hFF, 8'hFF, 0, 7, 1'b0, 1'b1, 1'b0);
        run_word("after_abort", 8'h81, 8'b1000_0001, 0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_word("reset4", 8'hF0, 8'hF0, 0, 4, 1'b1, 1'b0, 1'b0);
        run_word("after_reset", 8'h0F, 8'b0101_0101, 0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [DW-1:0] data;
            logic [DW-1:0] mask;
            int            cut;
            data = DW'($urandom);
            mask = DW'($urandom);
            cut  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DW - 1)) : -1;
            run_word("random", data, mask, int'($urandom_range(0, 3)), cut,
                     1'($urandom_range(0, 3) == 0), (n != 23) && 1'($urandom), 1'b1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream_a5();
        test_all_hits();
        test_pulse_hits();
        test_stall();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
